selu_lut_loader: RTL and testbench
==================================

SELU_LUT_LOADER -- requirements
Module: selu_lut_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of LUT entries written per load (power of two, ≤256).
REQ-002 Parameter TIMEOUT, default 1023, maximum idle cycles between accepted bytes during a load.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-006 chk_exp  input  16  expected checksum; latched on an accepted start.
REQ-007 s_valid  input  1  stream byte valid.
REQ-008 s_data  input  8  LUT entry (signed int8 SELU output), in address order.
REQ-009 s_ready  output  1  stream ready; a byte transfers when s_valid and s_ready are both 1.
REQ-010 lut_we  output  1  LUT write enable, one cycle per entry.
REQ-011 lut_waddr  output  8  LUT write address; unsigned reinterpretation of int8 x (x=0 -> 0x00, x=-1 -> 0xFF, x=-128 -> 0x80).
REQ-012 lut_wdata  output  8  LUT write data.
REQ-013 busy  output  1  high in LOAD and CHECK.
REQ-014 done  output  1  sticky; load completed with matching checksum.
REQ-015 err  output  1  sticky; load failed (checksum mismatch or timeout).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, CHECK and DONE, with DONE covering both pass and fail outcomes.
REQ-017 In IDLE or DONE, start=1 SHALL move to LOAD next cycle, clear done/err, zero count, sum and timer, and latch chk_exp.
REQ-018 s_ready SHALL be 1 only in LOAD; start in LOAD or CHECK is ignored.
REQ-019 Each accepted byte at cycle t SHALL produce lut_we=1 at t+1 with lut_waddr=count and lut_wdata=byte; count then increments (1-cycle latency, registered outputs).
REQ-020 lut_we SHALL be 0 in every cycle without a transfer in the previous cycle; back-to-back transfers give back-to-back writes.
REQ-021 sum SHALL be a 16-bit modular sum of bytes treated as unsigned 0..255; wrap-around is silent.
REQ-022 When the DEPTH-th byte is accepted, s_ready SHALL drop the next cycle and the FSM SHALL enter CHECK; no further bytes are accepted.
REQ-023 CHECK SHALL last one cycle: sum==latched chk_exp sets done=1, else err=1; then DONE.
REQ-024 The timer SHALL reset on each transfer and increment on each LOAD cycle without one; reaching TIMEOUT SHALL set err=1 and move to DONE with s_ready=0; entries already written remain written.
REQ-025 done and err SHALL never be 1 simultaneously and hold until the next accepted start or reset.
REQ-026 count SHALL be wide enough for DEPTH without wrap; lut_waddr is count[7:0].

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, s_ready=0, lut_we=0, lut_waddr=0, lut_wdata=0, busy=0, done=0, err=0, count/sum/timer=0.
REQ-028 Reset during LOAD SHALL abort without further writes; the next load restarts at address 0.

Verification
REQ-029 Full load: start with chk_exp = sum of 256 bytes, stream bytes 0x00..0xFF with s_valid held high -> 256 writes, addr 0..255, data = addr, done=1, err=0, busy low one cycle after CHECK.
REQ-030 Checksum mismatch: same stream with chk_exp off by 1 -> all 256 writes occur, err=1, done=0.
REQ-031 Gapped stream: s_valid toggles 1,0,0,1 -> lut_we follows transfers with 1-cycle lag only; addresses contiguous.
REQ-032 Timeout: TIMEOUT=8, stop after 10 bytes -> err=1 exactly 8 idle cycles after the last transfer; 10 writes total.
REQ-033 Start ignored: start pulse at byte 100 of a load -> load continues, count unaffected, 256 writes.
REQ-034 Reset mid-load at byte 50, then a new full load -> first write after reset has lut_waddr=0; done=1 with the correct checksum.

Source files
------------

// File: rtl/selu_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : selu_lut_loader
// Description : Streams DEPTH signed int8 SELU samples into a LUT write port
//               in address order. It keeps a 16-bit modular checksum of the
//               bytes and checks it against a value captured at start. An
//               idle-gap watchdog aborts a stalled load.
// Ports       : clk, rst_n (async, active-low)
//               start, chk_exp[15:0]          - load request / expected sum
//               s_valid, s_data[7:0], s_ready - byte stream (valid/ready)
//               lut_we, lut_waddr, lut_wdata  - registered LUT write port
//               busy, done, err               - status (done/err sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module selu_lut_loader #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] chk_exp,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        lut_we,
    output logic [7:0]  lut_waddr,
    output logic [7:0]  lut_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Wide enough to hold TIMEOUT itself.
    localparam int c_tw = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Nine bits always hold DEPTH (up to 256) without wrapping.
    localparam logic [8:0]      c_last_idx  = 9'(DEPTH - 1);
    localparam logic [c_tw-1:0] c_timer_max = c_tw'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [8:0]      count_q, count_d;
    logic [15:0]     sum_q, sum_d;
    logic [15:0]     chk_q, chk_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            lut_we_q, lut_we_d;
    logic [7:0]      lut_waddr_q, lut_waddr_d;
    logic [7:0]      lut_wdata_q, lut_wdata_d;
    logic            w_xfer;

    assign w_xfer = s_valid && (state_q == c_st_load);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_d       = sum_q;
        chk_d       = chk_q;
        timer_d     = timer_q;
        done_d      = done_q;
        err_d       = err_q;
        lut_we_d    = 1'b0;
        lut_waddr_d = lut_waddr_q;
        lut_wdata_d = lut_wdata_q;

        case (state_q)
            c_st_idle, c_st_done: begin
                if (start) begin
                    state_d = c_st_load;
                    count_d = '0;
                    sum_d   = '0;
                    timer_d = '0;
                    chk_d   = chk_exp;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            c_st_load: begin
                if (w_xfer) begin
                    lut_we_d    = 1'b1;
                    lut_waddr_d = count_q[7:0];
                    lut_wdata_d = s_data;
                    count_d     = count_q + 9'd1;
                    // Bytes summed as unsigned; the 16-bit wrap is intended.
                    sum_d       = sum_q + {8'h00, s_data};
                    timer_d     = '0;
                    if (count_q == c_last_idx) begin
                        state_d = c_st_check;
                    end
                end else begin
                    timer_d = timer_q + c_tw'(1);
                    // This idle cycle brings the timer up to TIMEOUT.
                    if (timer_q == c_timer_max) begin
                        err_d   = 1'b1;
                        state_d = c_st_done;
                    end
                end
            end
            c_st_check: begin
                if (sum_q == chk_q) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = c_st_done;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_st_idle;
            count_q     <= '0;
            sum_q       <= '0;
            chk_q       <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lut_we_q    <= 1'b0;
            lut_waddr_q <= '0;
            lut_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            chk_q       <= chk_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lut_we_q    <= lut_we_d;
            lut_waddr_q <= lut_waddr_d;
            lut_wdata_q <= lut_wdata_d;
        end
    end

    assign s_ready   = (state_q == c_st_load);
    assign busy      = (state_q == c_st_load) || (state_q == c_st_check);
    assign done      = done_q;
    assign err       = err_q;
    assign lut_we    = lut_we_q;
    assign lut_waddr = lut_waddr_q;
    assign lut_wdata = lut_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_selu_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_selu_lut_loader
// Description : Self-checking bench for selu_lut_loader. It keeps a
//               transaction-level model (accepted count, running sum, idle
//               gap, outcome) and checks every cycle against it. It also makes
//               directed end-of-load checks on write count, outcome and
//               timeout lag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_selu_lut_loader;

    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] chk_exp = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, lut_we, busy, done, err;
    logic [7:0]  lut_waddr, lut_wdata;

    selu_lut_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chk_exp   (chk_exp),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit         m_loading, m_checking, m_done, m_err;
    int         m_acc, m_sum, m_idle, m_chk;
    bit         e_we;
    logic [7:0] e_waddr, e_wdata;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc_n = 0;
    int         obs_writes = 0;
    int         first_addr = -1;
    int         err_rise = -1;
    int         last_xfer = -1;
    logic       prev_err = 1'b0;
    logic [7:0] bytes [256];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc_n);
        end
    endtask

    function automatic logic [15:0] csum();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(bytes[i]);
        return 16'(s % 65536);
    endfunction

    task automatic model_clear();
        m_loading = 0; m_checking = 0; m_done = 0; m_err = 0;
        m_acc = 0; m_sum = 0; m_idle = 0; m_chk = 0;
        e_we = 0; e_waddr = '0; e_wdata = '0;
    endtask

    // One clock: drive inputs, advance the model, check every output.
    task automatic cyc(input bit v, input logic [7:0] d, input bit st, input logic [15:0] ce);
        bit xfer;
        s_valid = v; s_data = d; start = st; chk_exp = ce;
        xfer = v && m_loading;
        e_we = xfer;
        if (xfer) begin
            e_waddr = m_acc[7:0];
            e_wdata = d;
        end
        if (m_loading) begin
            if (xfer) begin
                m_sum  = (m_sum + int'(d)) % 65536;
                m_acc  = m_acc + 1;
                m_idle = 0;
                if (m_acc == DEPTH) begin
                    m_loading = 0; m_checking = 1;
                end
            end else begin
                m_idle = m_idle + 1;
                if (m_idle == TIMEOUT) begin
                    m_loading = 0; m_err = 1;
                end
            end
        end else if (m_checking) begin
            m_checking = 0;
            if (m_sum == m_chk) m_done = 1; else m_err = 1;
        end else if (st) begin
            m_loading = 1; m_done = 0; m_err = 0;
            m_acc = 0; m_sum = 0; m_idle = 0; m_chk = int'(ce);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        chk("s_ready", 16'(s_ready), 16'(m_loading));
        chk("busy",    16'(busy),    16'(m_loading || m_checking));
        chk("done",    16'(done),    16'(m_done));
        chk("err",     16'(err),     16'(m_err));
        chk("lut_we",  16'(lut_we),  16'(e_we));
        if (e_we) begin
            chk("lut_waddr", 16'(lut_waddr), 16'(e_waddr));
            chk("lut_wdata", 16'(lut_wdata), 16'(e_wdata));
        end
        if (lut_we === 1'b1) begin
            if (obs_writes == 0) first_addr = int'(lut_waddr);
            obs_writes++;
        end
        if (err === 1'b1 && prev_err !== 1'b1) err_rise = cyc_n;
        prev_err = err;
        s_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_s_ready", 16'(s_ready), 16'd0);
        chk("rst_lut_we", 16'(lut_we), 16'd0);
        chk("rst_waddr", 16'(lut_waddr), 16'd0);
        chk("rst_wdata", 16'(lut_wdata), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        s_valid = 1'b1; s_data = 8'hA5; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_we", 16'(lut_we), 16'd0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        prev_err = 1'b0;
    endtask

    task automatic begin_load(input logic [15:0] ce);
        prev_err   = 1'b0;
        err_rise   = -1;
        last_xfer  = -1;
        cyc(1'b0, 8'($urandom), 1'b1, ce);
        obs_writes = 0;
        first_addr = -1;
    endtask

    // Stream bytes[] until the model leaves loading. stop_after limits how
    // many bytes are offered; start_at issues a stray start; abort_at resets.
    task automatic feed(input int gap_pct, input bit pattern, input int stop_after,
                        input int start_at, input int abort_at);
        int idx = 0;
        int k = 0;
        bit v, st, sent, was_loading;
        sent = 0;
        while (m_loading && k < 4000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                do_reset();
                return;
            end
            if (pattern) v = (k % 4 == 0) || (k % 4 == 3);
            else         v = ($urandom_range(99) >= gap_pct);
            if (idx >= stop_after) v = 0;
            st = (idx == start_at) && !sent;
            if (st) sent = 1;
            was_loading = m_loading;
            if (v && was_loading) last_xfer = cyc_n + 1;
            cyc(v, bytes[idx & 255], st, ~m_chk[15:0]);
            if (v && was_loading) idx++;
            k++;
        end
        if (k >= 4000) begin
            n_cmp++; n_err++;
            $error("FAIL feed_budget observed=%0d expected=<4000 cycles", k);
        end
    endtask

    task automatic settle();
        repeat (3) cyc(1'b0, 8'($urandom), 1'b0, 16'h0000);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cs;
        model_clear();
        do_reset();

        // Full load 0x00..0xFF, matching checksum
        for (int i = 0; i < 256; i++) bytes[i] = 8'(i);
        cs = csum();
        begin_load(cs);
        feed(0, 1'b0, 999, -1, -1);
        settle();
        chk("full_writes", 16'(obs_writes), 16'd256);
        chk("full_first_addr", 16'(first_addr), 16'd0);
        chk("full_done", 16'(done), 16'd1);
        chk("full_err", 16'(err), 16'd0);

        // Same stream, checksum off by one
        begin_load(cs + 16'd1);
        feed(0, 1'b0, 999, -1, -1);
        settle();
        chk("mis_writes", 16'(obs_writes), 16'd256);
        chk("mis_done", 16'(done), 16'd0);
        chk("mis_err", 16'(err), 16'd1);

        // Gapped 1,0,0,1 pattern with random bytes
        for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
        begin_load(csum());
        feed(0, 1'b1, 999, -1, -1);
        settle();
        chk("gap_writes", 16'(obs_writes), 16'd256);
        chk("gap_done", 16'(done), 16'd1);

        // Timeout after 10 bytes
        begin_load(csum());
        feed(0, 1'b0, 10, -1, -1);
        settle();
        chk("to_writes", 16'(obs_writes), 16'd10);
        chk("to_err", 16'(err), 16'd1);
        chk("to_done", 16'(done), 16'd0);
        chk("to_lag", 16'(err_rise - last_xfer), 16'(TIMEOUT));

        // Stray start at byte 100 (with a different chk_exp) is ignored
        for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
        begin_load(csum());
        feed(20, 1'b0, 999, 100, -1);
        settle();
        chk("ign_writes", 16'(obs_writes), 16'd256);
        chk("ign_done", 16'(done), 16'd1);

        // Reset at byte 50, then a fresh full load
        begin_load(csum());
        feed(0, 1'b0, 999, -1, 50);
        chk("abort_writes", 16'(obs_writes), 16'd50);
        repeat (2) cyc(1'b1, 8'($urandom), 1'b0, 16'h0000);
        begin_load(csum());
        feed(10, 1'b0, 999, -1, -1);
        settle();
        chk("rel_first_addr", 16'(first_addr), 16'd0);
        chk("rel_writes", 16'(obs_writes), 16'd256);
        chk("rel_done", 16'(done), 16'd1);

        // Random loads, random gaps, random checksum correctness
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
            cs = csum();
            if ($urandom_range(1) == 1) cs = cs ^ 16'(1 << $urandom_range(15));
            begin_load(cs);
            feed(30, 1'b0, 999, -1, -1);
            settle();
            chk("rnd_writes", 16'(obs_writes), 16'(m_acc));
            chk("rnd_done", 16'(done), 16'(m_done));
            chk("rnd_err", 16'(err), 16'(m_err));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
